// File: rtl/bbqm_pkg.sv
// Shared definitions for the queue-status path: widths, queue capacity,
// per-customer service time and the count-update encoding.
package bbqm_pkg;

  localparam int PCOUNT_W  = 3;
  localparam int MAX_COUNT = 7;
  localparam int TCOUNT_W  = 2;
  localparam int WTIME_W   = 5;
  localparam int SVC_TIME  = 3;

  // Wide enough for SVC_TIME * (MAX_COUNT + 3 - 1) without overflow.
  localparam int CALC_W = PCOUNT_W + TCOUNT_W + 2;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } upd_e;

endpackage

// File: rtl/queue_counter_if.sv
// Queue-status bus between the sensor/switch side and the counter.
//   front_sensor, back_sensor : arrival / departure photocells (async levels)
//   Tcount                    : number of open tellers
//   Pcount, Wtime             : people in queue, estimated waiting time
//   full, empty               : queue-limit flags
// master drives sensors and Tcount; slave (the counter) drives the status.
interface queue_counter_if import bbqm_pkg::*; ;

  logic                front_sensor;
  logic                back_sensor;
  logic [TCOUNT_W-1:0] Tcount;
  logic [PCOUNT_W-1:0] Pcount;
  logic [WTIME_W-1:0]  Wtime;
  logic                full;
  logic                empty;

  modport master (
    output front_sensor, back_sensor, Tcount,
    input  Pcount, Wtime, full, empty
  );

  modport slave (
    input  front_sensor, back_sensor, Tcount,
    output Pcount, Wtime, full, empty
  );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus history flop; emits a one-cycle pulse on each
// rising edge of an asynchronous level input.
//   clk, rst : clock, async active-high reset
//   din      : asynchronous level input
//   pulse    : one-cycle high per rising edge of din
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign pulse = sync2 & ~hist;

endmodule

// File: rtl/queue_counter.sv
// Queue counter: counts customers from two photocells, saturating at 0 and
// MAX_COUNT, and produces a registered waiting-time estimate from the count
// and the number of open tellers.
//   clk, rst : clock, async active-high reset
//   bus      : queue_counter_if slave (sensors/Tcount in, Pcount/Wtime/flags out)
module queue_counter import bbqm_pkg::*; (
  input logic             clk,
  input logic             rst,
  queue_counter_if.slave  bus
);

  logic                arr;
  logic                dep;
  logic [TCOUNT_W-1:0] tcount_q;
  logic [PCOUNT_W-1:0] pcount;
  logic [WTIME_W-1:0]  wtime;
  upd_e                upd;
  logic [CALC_W-1:0]   num;
  logic [CALC_W-1:0]   quot;

  edge_sync u_front (.clk(clk), .rst(rst), .din(bus.front_sensor), .pulse(arr));
  edge_sync u_back  (.clk(clk), .rst(rst), .din(bus.back_sensor),  .pulse(dep));

  // Simultaneous arrival and departure cancel out, even at the limits.
  always_comb begin
    upd = HOLD;
    case ({arr, dep})
      2'b10:   upd = (pcount < PCOUNT_W'(MAX_COUNT)) ? INC : HOLD;
      2'b01:   upd = (pcount != '0) ? DEC : HOLD;
      default: upd = HOLD;
    endcase
  end

  // Ceiling-style estimate: SVC_TIME*(P+T-1)/T; T is 1..3 so a small case
  // replaces a general divider.
  always_comb begin
    num  = CALC_W'(SVC_TIME) *
           (CALC_W'(pcount) + CALC_W'(tcount_q) - CALC_W'(1));
    quot = '0;
    if (pcount != '0) begin
      case (tcount_q)
        2'd1:    quot = num;
        2'd2:    quot = num >> 1;
        2'd3:    quot = num / CALC_W'(3);
        default: quot = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcount_q <= '0;
      pcount   <= '0;
      wtime    <= '0;
    end else begin
      // Tcount is a static switch: one register stage is enough, a
      // metastable sample is simply recomputed on the next cycle.
      tcount_q <= bus.Tcount;
      wtime    <= quot[WTIME_W-1:0];
      case (upd)
        INC:     pcount <= pcount + PCOUNT_W'(1);
        DEC:     pcount <= pcount - PCOUNT_W'(1);
        default: pcount <= pcount;
      endcase
    end
  end

  assign bus.Pcount = pcount;
  assign bus.Wtime  = wtime;
  assign bus.full   = (pcount == PCOUNT_W'(MAX_COUNT));
  assign bus.empty  = (pcount == '0);

endmodule
